// File: rtl/fifo_pkg.sv
// Shared types and helpers for the read-domain FIFO packer.
package fifo_pkg;

    // FILL gathers FIFO words; DRAIN pushes out whatever is held after a flush.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } pack_state_t;

    // Lane-valid mask with the lowest cnt bits set.
    function automatic logic [31:0] keep_mask(input logic [31:0] cnt);
        return (32'd1 << cnt) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port, flush request and packed output stream.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) ();

    logic                          fifo_empty;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_r_en;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH*LANES-1:0]   out_data;
    logic [LANES-1:0]              out_keep;
    logic                          busy;

    // Packer side: consumes the FIFO, produces the packed stream.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  flush,
        input  out_ready,
        output fifo_r_en,
        output out_valid,
        output out_data,
        output out_keep,
        output busy
    );

    // Environment side: the FIFO plus the downstream consumer.
    modport slave (
        output fifo_empty,
        output fifo_data,
        output flush,
        output out_ready,
        input  fifo_r_en,
        input  out_valid,
        input  out_data,
        input  out_keep,
        input  busy
    );

endinterface

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port and packs LANES consecutive words into one
// wide word (first word in lane 0) with a lane-keep mask. A flush pulse emits
// a partial word so a short burst never sits in the accumulator.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    fifo_rd_packer_if.master bus
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(LANES);
    localparam int OW = DATA_WIDTH * LANES;

    pack_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_acc [LANES];
    logic [CW-1:0]         r_accCnt;
    logic                  r_pend;
    logic                  r_outValid;
    logic [OW-1:0]         r_outData;
    logic [LANES-1:0]      r_outKeep;

    logic [CW:0]           w_occupancy;
    logic                  w_rEn;
    logic                  w_outFree;
    logic                  w_accFull;
    logic                  w_fullXfer;
    logic                  w_partXfer;
    logic                  w_load;
    logic [IW-1:0]         w_capIdx;
    logic [LANES-1:0]      w_loadKeep;
    logic [OW-1:0]         w_loadData;

    // Words held plus the one in flight must never exceed LANES.
    assign w_occupancy = {1'b0, r_accCnt} + (CW+1)'(r_pend);
    assign w_rEn       = rrst_n & ~bus.fifo_empty & (r_state == FILL)
                       & (w_occupancy < (CW+1)'(LANES));

    assign w_outFree   = ~r_outValid | bus.out_ready;
    assign w_accFull   = (r_accCnt == CW'(LANES));
    assign w_fullXfer  = w_accFull & w_outFree;
    assign w_partXfer  = (r_state == DRAIN) & ~r_pend & w_outFree
                       & (r_accCnt != '0) & ~w_accFull;
    assign w_load      = w_fullXfer | w_partXfer;

    assign w_capIdx    = r_accCnt[IW-1:0];
    assign w_loadKeep  = LANES'(keep_mask(32'(r_accCnt)));

    // Build the outgoing word, zeroing lanes the keep mask does not cover.
    always_comb begin
        w_loadData = '0;
        for (int i = 0; i < LANES; i++) begin
            w_loadData[i*DATA_WIDTH +: DATA_WIDTH] = w_loadKeep[i] ? r_acc[i] : '0;
        end
    end

    // Accumulator lanes: the word read last cycle lands at the current count.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_pend) begin
            r_acc[w_capIdx] <= bus.fifo_data;
        end
    end

    // Control FSM with the fill counter, in-flight flag and output register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state    <= FILL;
            r_accCnt   <= '0;
            r_pend     <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outKeep  <= '0;
        end else begin
            r_pend <= w_rEn;

            if (w_load) begin
                r_accCnt <= '0;
            end else if (r_pend) begin
                r_accCnt <= r_accCnt + CW'(1);
            end

            if (w_load) begin
                r_outValid <= 1'b1;
                r_outData  <= w_loadData;
                r_outKeep  <= w_loadKeep;
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end

            case (r_state)
                FILL: begin
                    if (bus.flush && !w_fullXfer && ((r_accCnt != '0) || r_pend)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_load || (!r_pend && (r_accCnt == '0))) begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign bus.fifo_r_en = w_rEn;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_keep  = r_outKeep;
    assign bus.busy      = (r_accCnt != '0) | r_pend | r_outValid | (r_state == DRAIN);

    // A capture can only happen into a free lane.
    a_noCaptureFull: assert property (@(posedge rclk) disable iff (!rrst_n)
        r_pend |-> !w_accFull);

    // A stalled output word must not change under the consumer.
    a_stableStall: assert property (@(posedge rclk) disable iff (!rrst_n)
        (r_outValid && !bus.out_ready) |=> ($stable(r_outData) && $stable(r_outKeep)));

    // The FIFO is never read past empty.
    a_noReadEmpty: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(w_rEn && bus.fifo_empty));

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a 1-cycle registered-read FIFO model.
module tb_fifo_rd_packer;

    logic rclk = 1'b0;
    logic rrst_n;

    fifo_rd_packer_if #(.DATA_WIDTH(8), .LANES(4)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(8), .LANES(4)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    int testsRun    = 0;
    int failCount   = 0;
    int readCount   = 0;
    int readErrors  = 0;
    int acceptCount = 0;
    int base;
    int acceptBase;
    logic [7:0] fifoQ [$];

    always #5 rclk = ~rclk;

    // FIFO model: registered empty flag, data valid the cycle after a read.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            bus.fifo_empty <= (fifoQ.size() == 0);
        end else begin
            if (bus.fifo_r_en && bus.fifo_empty) readErrors++;
            if (bus.fifo_r_en && !bus.fifo_empty) begin
                bus.fifo_data <= fifoQ.pop_front();
                readCount++;
            end
            bus.fifo_empty <= (fifoQ.size() == 0);
        end
    end

    // Count words the consumer takes.
    always @(posedge rclk) begin
        if (rrst_n && bus.out_valid && bus.out_ready) acceptCount++;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifoQ.push_back(b);
    endtask

    task automatic pulseFlush();
        bus.flush = 1'b1;
        @(negedge rclk);
        bus.flush = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge rclk);
        checkOutput(tag, 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        rrst_n        = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge rclk);

        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_data",  64'(bus.out_data),  64'd0);
        checkOutput("rst_keep",  64'(bus.out_keep),  64'd0);
        checkOutput("rst_busy",  64'(bus.busy),      64'd0);
        checkOutput("rst_ren",   64'(bus.fifo_r_en), 64'd0);
        rrst_n = 1'b1;
        @(negedge rclk);

        // Full word with a ready consumer.
        base = readCount;
        acceptBase = acceptCount;
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        waitValid("t1_valid");
        checkOutput("t1_data",  64'(bus.out_data), 64'h44332211);
        checkOutput("t1_keep",  64'(bus.out_keep), 64'hF);
        checkOutput("t1_reads", 64'(readCount - base), 64'd4);
        @(negedge rclk);
        checkOutput("t1_done",   64'(bus.out_valid), 64'd0);
        checkOutput("t1_busy",   64'(bus.busy), 64'd0);
        checkOutput("t1_accept", 64'(acceptCount - acceptBase), 64'd1);

        // Backpressure: first word held, second word waits in the accumulator.
        bus.out_ready = 1'b0;
        base = readCount;
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        waitValid("t2_valid");
        checkOutput("t2_data0", 64'(bus.out_data), 64'h04030201);
        checkOutput("t2_keep0", 64'(bus.out_keep), 64'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            checkOutput("t2_hold", 64'(bus.out_data), 64'h04030201);
        end
        checkOutput("t2_reads", 64'(readCount - base), 64'd8);
        checkOutput("t2_stall", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge rclk);
        checkOutput("t2_b2b",   64'(bus.out_valid), 64'd1);
        checkOutput("t2_data1", 64'(bus.out_data), 64'h08070605);
        checkOutput("t2_keep1", 64'(bus.out_keep), 64'hF);
        @(negedge rclk);
        checkOutput("t2_done",  64'(bus.out_valid), 64'd0);

        // Flush of a two-byte partial word.
        applyStimulus(8'hAA); applyStimulus(8'hBB);
        repeat (6) @(negedge rclk);
        checkOutput("t3_held",  64'(bus.busy), 64'd1);
        checkOutput("t3_noout", 64'(bus.out_valid), 64'd0);
        pulseFlush();
        waitValid("t3_valid");
        checkOutput("t3_data", 64'(bus.out_data), 64'h0000BBAA);
        checkOutput("t3_keep", 64'(bus.out_keep), 64'h3);
        @(negedge rclk);
        checkOutput("t3_done", 64'(bus.out_valid), 64'd0);
        checkOutput("t3_idle", 64'(bus.busy), 64'd0);

        // Flush while idle does nothing.
        acceptBase = acceptCount;
        pulseFlush();
        repeat (3) @(negedge rclk);
        checkOutput("t4_valid",  64'(bus.out_valid), 64'd0);
        checkOutput("t4_busy",   64'(bus.busy), 64'd0);
        checkOutput("t4_accept", 64'(acceptCount - acceptBase), 64'd0);

        // Flush in the cycle the third read is issued.
        base = readCount;
        applyStimulus(8'hA1); applyStimulus(8'hB2); applyStimulus(8'hCC);
        for (int i = 0; i < 20 && !((readCount == base + 2) && bus.fifo_r_en); i++)
            @(negedge rclk);
        checkOutput("t5_ren3", 64'(bus.fifo_r_en), 64'd1);
        pulseFlush();
        waitValid("t5_valid");
        checkOutput("t5_data",  64'(bus.out_data), 64'h00CCB2A1);
        checkOutput("t5_keep",  64'(bus.out_keep), 64'h7);
        checkOutput("t5_reads", 64'(readCount - base), 64'd3);
        @(negedge rclk);
        checkOutput("t5_idle",  64'(bus.busy), 64'd0);

        // Reset with two bytes held, then a clean word.
        applyStimulus(8'h5A); applyStimulus(8'h6B);
        repeat (6) @(negedge rclk);
        checkOutput("t6_held", 64'(bus.busy), 64'd1);
        rrst_n = 1'b0;
        #1;
        checkOutput("t6_rvalid", 64'(bus.out_valid), 64'd0);
        checkOutput("t6_rbusy",  64'(bus.busy), 64'd0);
        checkOutput("t6_rren",   64'(bus.fifo_r_en), 64'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        applyStimulus(8'h9C); applyStimulus(8'h8D);
        applyStimulus(8'h7E); applyStimulus(8'h6F);
        waitValid("t6_valid");
        checkOutput("t6_data", 64'(bus.out_data), 64'h6F7E8D9C);
        checkOutput("t6_keep", 64'(bus.out_keep), 64'hF);
        @(negedge rclk);
        checkOutput("t6_done", 64'(bus.out_valid), 64'd0);

        checkOutput("read_err", 64'(readErrors), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
